// File: rtl/oppm_encoder_if.sv
// Packet handshake and chip-stream output between the control FSMs and the OPPM encoder.
interface oppm_encoder_if #(
    parameter int unsigned N_PKT = 48
);
    logic             start_ENC;
    logic [N_PKT-1:0] data_ENC;
    logic             avail_ENC;
    logic             led_out;

    modport master (output start_ENC, output data_ENC, input avail_ENC, input led_out);
    modport slave  (input start_ENC, input data_ENC, output avail_ENC, output led_out);
endinterface

// File: rtl/oppm_encoder.sv
// OPPM transmitter: preamble, sync gap, one pulse frame per symbol (MSB first), guard chip.
module oppm_encoder #(
    parameter int unsigned N_PKT          = 48,
    parameter int unsigned BITS_PER_SYM   = 2,
    parameter int unsigned PULSE_CHIPS    = 4,
    parameter int unsigned CHIP_CYCLES    = 16,
    parameter int unsigned PREAMBLE_CHIPS = 8
) (
    input logic          clk,
    input logic          rst_n,
    oppm_encoder_if.slave bus
);
    localparam int unsigned M        = 1 << BITS_PER_SYM;
    localparam int unsigned NSYM     = N_PKT / BITS_PER_SYM;
    localparam int unsigned F        = M - 1 + PULSE_CHIPS;
    localparam int unsigned CHIP_MAX = (F > PREAMBLE_CHIPS) ? F : PREAMBLE_CHIPS;
    localparam int unsigned CYC_W    = (CHIP_CYCLES > 1) ? $clog2(CHIP_CYCLES) : 1;
    localparam int unsigned CHIP_W   = (CHIP_MAX > 1) ? $clog2(CHIP_MAX) : 1;
    localparam int unsigned SYM_W    = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam int unsigned CMP_W    = CHIP_W + BITS_PER_SYM + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SYNC_GAP,
        ST_SYMBOL,
        ST_GUARD
    } state_e;

    state_e            state_q, state_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [CHIP_W-1:0] chip_q, chip_d;
    logic [SYM_W-1:0]  sym_q, sym_d;
    logic [N_PKT-1:0]  shift_q, shift_d;
    logic              led_q, led_d;
    logic              avail_q, avail_d;

    logic                    chip_end;
    logic [BITS_PER_SYM-1:0] sym_bits;
    logic [CMP_W-1:0]        pulse_lo, pulse_hi, chip_ext;

    // Next-state, counters and shift register
    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        chip_d   = chip_q;
        sym_d    = sym_q;
        shift_d  = shift_q;
        chip_end = (cyc_q == CYC_W'(CHIP_CYCLES - 1));

        if (state_q == ST_IDLE) begin
            if (bus.start_ENC) begin
                state_d = ST_PREAMBLE;
                cyc_d   = '0;
                chip_d  = '0;
                sym_d   = '0;
                shift_d = bus.data_ENC;
            end
        end else begin
            cyc_d = chip_end ? '0 : cyc_q + CYC_W'(1);
            if (chip_end) begin
                chip_d = chip_q + CHIP_W'(1);
                case (state_q)
                    ST_PREAMBLE: begin
                        if (chip_q == CHIP_W'(PREAMBLE_CHIPS - 1)) begin
                            state_d = ST_SYNC_GAP;
                            chip_d  = '0;
                        end
                    end
                    ST_SYNC_GAP: begin
                        state_d = ST_SYMBOL;
                        chip_d  = '0;
                        sym_d   = '0;
                    end
                    ST_SYMBOL: begin
                        if (chip_q == CHIP_W'(F - 1)) begin
                            chip_d  = '0;
                            shift_d = shift_q << BITS_PER_SYM;
                            if (sym_q == SYM_W'(NSYM - 1)) begin
                                state_d = ST_GUARD;
                                sym_d   = '0;
                            end else begin
                                sym_d = sym_q + SYM_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        chip_d  = '0;
                    end
                endcase
            end
        end
    end

    // Outputs are computed from the next state so they line up with it after the edge
    always_comb begin
        sym_bits = shift_d[N_PKT-1 -: BITS_PER_SYM];
        pulse_lo = CMP_W'(sym_bits);
        pulse_hi = pulse_lo + CMP_W'(PULSE_CHIPS - 1);
        chip_ext = CMP_W'(chip_d);
        led_d    = (state_d == ST_PREAMBLE) ||
                   ((state_d == ST_SYMBOL) && (chip_ext >= pulse_lo) && (chip_ext <= pulse_hi));
        avail_d  = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            chip_q  <= '0;
            sym_q   <= '0;
            shift_q <= '0;
            led_q   <= 1'b0;
            avail_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            chip_q  <= chip_d;
            sym_q   <= sym_d;
            shift_q <= shift_d;
            led_q   <= led_d;
            avail_q <= avail_d;
        end
    end

    assign bus.led_out   = led_q;
    assign bus.avail_ENC = avail_q;
endmodule

// File: tb/tb_oppm_encoder.sv
// Directed bench for oppm_encoder: default-parameter frames plus a narrow-pulse, one-cycle-chip instance.
module tb_oppm_encoder;
    localparam logic [47:0] READY = 48'h1f1f1f1f1f99;
    localparam logic [47:0] ACK   = 48'h2d2d2d2d2d66;
    localparam logic [47:0] SWEEP = 48'ha5a5a5a5a512;
    localparam int FRAME = 2848;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic wave [0:2999];
    logic avw  [0:2999];

    always #5 clk = ~clk;

    oppm_encoder_if #(.N_PKT(48)) m_if ();
    oppm_encoder_if #(.N_PKT(48)) s_if ();

    oppm_encoder u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m_if.slave)
    );

    oppm_encoder #(
        .N_PKT(48), .BITS_PER_SYM(4), .PULSE_CHIPS(1), .CHIP_CYCLES(1), .PREAMBLE_CHIPS(8)
    ) u_dut_sweep (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (s_if.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Independent reference of the chip stream for cycle k after the accepting edge
    function automatic logic model_led(input logic [47:0] d, input int k, input int b,
                                       input int p, input int cc, input int pre);
        int m, f, nsym, chip, j, sym, c, s;
        logic [47:0] t;
        m    = 1 << b;
        f    = m - 1 + p;
        nsym = 48 / b;
        chip = k / cc;
        if (chip < pre) return 1'b1;
        if (chip == pre) return 1'b0;
        j = chip - pre - 1;
        if (j >= nsym * f) return 1'b0;
        sym = j / f;
        c   = j % f;
        t   = d >> (48 - b * (sym + 1));
        s   = int'(t[7:0]) & (m - 1);
        return (c >= s) && (c <= s + p - 1);
    endfunction

    // Issue a start from a negedge, then record ncyc cycles; optional extra start pulses and data change
    task automatic run_frame(input logic [47:0] d, input int ncyc, input int chg_at,
                             input int sa, input int sb);
        m_if.start_ENC = 1'b1;
        m_if.data_ENC  = d;
        @(posedge clk);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            wave[k] = m_if.led_out;
            avw[k]  = m_if.avail_ENC;
            m_if.start_ENC = (k == sa) || (k == sb);
            if (k == chg_at) m_if.data_ENC = '0;
        end
        m_if.start_ENC = 1'b0;
    endtask

    task automatic frame_check(input string tag, input logic [47:0] d);
        int mis, busy_hi;
        mis = 0;
        busy_hi = 0;
        for (int k = 0; k < FRAME; k++) begin
            if (wave[k] !== model_led(d, k, 2, 4, 16, 8)) mis++;
            if (avw[k] !== 1'b0) busy_hi++;
        end
        check({tag, "_wave_mismatches"}, 64'(mis), 64'd0);
        check({tag, "_avail_during_frame"}, 64'(busy_hi), 64'd0);
        check({tag, "_avail_at_2848"}, 64'(avw[FRAME]), 64'd1);
    endtask

    task automatic idle_check(input string tag);
        check({tag, "_avail"}, 64'(m_if.avail_ENC), 64'd1);
        check({tag, "_led"}, 64'(m_if.led_out), 64'd0);
        check({tag, "_sweep_avail"}, 64'(s_if.avail_ENC), 64'd1);
    endtask

    initial begin
        int ready_cyc [21] = '{0, 127, 128, 143, 144, 207, 208, 256, 272, 320, 336,
                               400, 416, 464, 480, 2720, 2736, 2784, 2800, 2832, 2847};
        logic ready_exp [21] = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0,
                                 0, 1, 1, 0, 0, 1, 1, 0, 0, 0};
        int cnt;

        // Reset held with start asserted: block stays idle
        rst_n = 1'b0;
        m_if.start_ENC = 1'b1;
        m_if.data_ENC  = READY;
        s_if.start_ENC = 1'b1;
        s_if.data_ENC  = SWEEP;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            idle_check($sformatf("reset_hold%0d", i));
        end
        rst_n = 1'b1;
        m_if.start_ENC = 1'b0;
        s_if.start_ENC = 1'b0;
        @(negedge clk);
        idle_check("post_reset");

        // READY packet with hand-derived waypoints
        run_frame(READY, FRAME + 1, -1, -1, -1);
        frame_check("ready", READY);
        for (int i = 0; i < 21; i++)
            check($sformatf("ready_led_c%0d", ready_cyc[i]), 64'(wave[ready_cyc[i]]), 64'(ready_exp[i]));
        check("ready_avail_c2847", 64'(avw[2847]), 64'd0);

        // Back-to-back ACK start in first idle cycle; data_ENC cleared after acceptance
        run_frame(ACK, FRAME + 1, 0, -1, -1);
        check("b2b_led_c0", 64'(wave[0]), 64'd1);
        check("b2b_avail_c0", 64'(avw[0]), 64'd0);
        check("ack_led_c272", 64'(wave[272]), 64'd0);
        check("ack_led_c288", 64'(wave[288]), 64'd1);
        frame_check("ack", ACK);

        // Busy rejection: start pulses mid-frame and in the final guard cycle
        run_frame(READY, FRAME + 22, -1, 10, 2847);
        frame_check("busy", READY);
        cnt = 0;
        for (int k = FRAME; k < FRAME + 22; k++)
            if (wave[k] !== 1'b0 || avw[k] !== 1'b1) cnt++;
        check("busy_no_second_frame", 64'(cnt), 64'd0);

        // Reset mid-frame at cycle 1000
        m_if.start_ENC = 1'b1;
        m_if.data_ENC  = READY;
        @(posedge clk);
        for (int k = 0; k <= 1000; k++) begin
            @(negedge clk);
            m_if.start_ENC = 1'b0;
        end
        check("midrst_led_before", 64'(m_if.led_out), 64'd1);
        rst_n = 1'b0;
        #1;
        idle_check("midrst_async");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge clk);
        idle_check("midrst_released");
        run_frame(READY, FRAME + 1, -1, -1, -1);
        frame_check("after_rst", READY);

        // Sweep instance: F=16, one-cycle chips, T=202
        s_if.start_ENC = 1'b1;
        s_if.data_ENC  = SWEEP;
        @(posedge clk);
        for (int k = 0; k < 210; k++) begin
            @(negedge clk);
            wave[k] = s_if.led_out;
            avw[k]  = s_if.avail_ENC;
            s_if.start_ENC = 1'b0;
        end
        check("sweep_led_c19", 64'(wave[19]), 64'd1);
        cnt = 0;
        for (int k = 9; k < 25; k++) if (wave[k] === 1'b1) cnt++;
        check("sweep_sym0_pulses", 64'(cnt), 64'd1);
        cnt = 0;
        for (int k = 0; k < 210; k++) if (wave[k] !== model_led(SWEEP, k, 4, 1, 1, 8)) cnt++;
        check("sweep_wave_mismatches", 64'(cnt), 64'd0);
        check("sweep_avail_c201", 64'(avw[201]), 64'd0);
        check("sweep_avail_c202", 64'(avw[202]), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/oppm_encoder.md
# oppm_encoder

Serializes one N_PKT-bit packet into an overlapping pulse-position-modulated (OPPM) chip stream on a single optical/LED output. It sits directly downstream of the transmitter and receiver control FSMs: they present a packet on data_ENC with a one-cycle start_ENC, and this block owns the line until the frame ends. On the link's far side, the OPPM decoder consumes led_out and produces data_DEC, avail_DEC and error_DEC.

## Interface
Parameters:
- N_PKT, 48, packet width in bits; must be a multiple of BITS_PER_SYM.
- BITS_PER_SYM, 2, bits per symbol; M = 2^BITS_PER_SYM pulse positions.
- PULSE_CHIPS, 4, pulse width in chips; must be ≥1. Pulses overlap adjacent positions when this is >1.
- CHIP_CYCLES, 16, clk cycles per chip; must be ≥1.
- PREAMBLE_CHIPS, 8, length of the all-high sync preamble in chips.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low.
- start_ENC  in  1  one-cycle request to transmit data_ENC; honoured only while avail_ENC=1.
- data_ENC  in  N_PKT  packet to send; sampled only on the accepting edge.
- avail_ENC  out  1  encoder idle and able to accept start_ENC.
- led_out  out  1  registered chip-stream output.

## Operation
- Derived constants:
  - NSYM = N_PKT/BITS_PER_SYM.
  - F = M-1+PULSE_CHIPS chips per symbol frame.
  - Total chips T = PREAMBLE_CHIPS + 1 + NSYM·F + 1.
- States: IDLE, PREAMBLE, SYNC_GAP, SYMBOL, GUARD.
- IDLE:
  - avail_ENC=1, led_out=0.
  - On start_ENC=1: latch data_ENC into the shift register, clear all counters, go to PREAMBLE.
- PREAMBLE: led_out=1 for PREAMBLE_CHIPS chips, then go to SYNC_GAP.
- SYNC_GAP: led_out=0 for 1 chip, then go to SYMBOL with symbol index 0.
- SYMBOL:
  - The current symbol s is the top BITS_PER_SYM bits of the shift register, so the packet goes out MSB first.
  - Within the frame, chip index c runs 0..F-1. led_out=1 iff s ≤ c ≤ s+PULSE_CHIPS-1.
  - After chip F-1, shift the register left by BITS_PER_SYM and increment the symbol index.
  - After symbol NSYM-1, go to GUARD.
- GUARD: led_out=0 for 1 chip, then go to IDLE.
- Counters:
  - Cycle-in-chip counter: 0..CHIP_CYCLES-1, wraps to 0 and advances the chip counter.
  - Chip counter: resets at each state or frame boundary.
  - Symbol counter: 0..NSYM-1.
  - Each counter is sized $clog2 of its range, minimum 1 bit. No arithmetic overflow is possible.
- avail_ENC=0 in every state except IDLE.
- start_ENC outside IDLE is ignored; it is not queued.
- data_ENC changes after the accepting edge have no effect on the frame.
- The block never reports errors. Timeout and retry belong to the upstream FSMs.

## Timing
- Reset values: state=IDLE, avail_ENC=1, led_out=0, shift register and all counters 0.
- Reset asserted mid-frame: on assertion, led_out→0, avail_ENC→1 and the frame is abandoned. After release the block waits in IDLE.
- Start acceptance and frame start:
  - Accepting edge: the rising clk edge with start_ENC=1 and state=IDLE.
  - On that same edge avail_ENC falls to 0 and led_out rises to 1, which is the first preamble cycle.
- Frame end:
  - led_out is fully determined for exactly T·CHIP_CYCLES cycles after the accepting edge.
  - avail_ENC returns to 1 on the edge ending the last GUARD cycle.
  - Default busy time: T = 8+1+24·7+1 = 178 chips = 2848 cycles.
- Back-to-back: start_ENC asserted in the first cycle avail_ENC=1 is accepted, so successive frames have zero extra idle cycles.
- led_out is a flop output with no combinational path from inputs.

## Test plan
- Reset: hold rst_n=0 with start_ENC=1 → avail_ENC=1, led_out=0 throughout. After release and start, the first frame starts normally.
- READY_PACKET 0x1f1f1f1f1f99, defaults:
  - Preamble: led_out high for cycles 0–127, low for cycles 128–143.
  - First symbols 0,1,3,3 → first-frame pulse at chips 0–3, second at chips 1–4, third and fourth at chips 3–6.
  - Last symbol 0x99 low bits 01 → chips 1–4.
  - avail_ENC returns to 1 at cycle 2848.
- Latch isolation: start with 0x2d2d2d2d2d66, then change data_ENC to 0 one cycle later → waveform matches a golden ACK-packet stream chip for chip.
- Busy rejection: pulse start_ENC at cycles 10 and 2847 → both ignored, exactly one frame is emitted, and avail_ENC rises at cycle 2848.
- Reset mid-frame: assert rst_n=0 at cycle 1000 → led_out=0 and avail_ENC=1 immediately. A new start after release gives a full 2848-cycle frame.
- Parameter sweep: CHIP_CYCLES=1, PULSE_CHIPS=1, BITS_PER_SYM=4 with packet 0xa5a5a5a5a512 → F=16, T=8+1+12·16+1=202 cycles. The first pulse is at chip 10, which is nibble 0xa.
